// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings,
// handshake level names, the double-width result bus and a negate helper.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int DoubleRegBus = 64;

  // Two's-complement negation of a 32-bit word.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for the EX stage (DIV / DIVU).
// Operands are latched as magnitudes; signs are re-applied when the
// iteration completes. Result is {remainder, quotient}.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [WIDTH-1:0]        opdata1_i,
  input  logic [WIDTH-1:0]        opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o,
  output logic                    busy_o
);

  div_state_e       state, state_next;
  logic [5:0]       cnt;
  logic [2*WIDTH-1:0] part;        // {partial remainder, dividend/quotient bits}
  logic [WIDTH-1:0] divisor;
  logic             signed_q;
  logic             neg_dividend;
  logic             neg_divisor;

  logic             accept;
  logic [WIDTH-1:0] abs_op1;
  logic [WIDTH-1:0] abs_op2;
  logic [2*WIDTH:0] part_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign accept  = (start_i == DivStart) && !annul_i;
  assign abs_op1 = (signed_div_i && opdata1_i[WIDTH-1]) ? neg32(opdata1_i) : opdata1_i;
  assign abs_op2 = (signed_div_i && opdata2_i[WIDTH-1]) ? neg32(opdata2_i) : opdata2_i;

  // One restoring step: shift, then trial-subtract the divisor from the upper half.
  // The remainder is always below the divisor, so bit WIDTH of trial is its sign.
  assign part_shift = {part, 1'b0};
  assign trial      = part_shift[2*WIDTH:WIDTH] - {1'b0, divisor};

  // Sign correction applied on the edge that leaves the iteration.
  assign quo_fix = (signed_q && (neg_dividend ^ neg_divisor)) ? neg32(part[WIDTH-1:0])
                                                              : part[WIDTH-1:0];
  assign rem_fix = (signed_q && neg_dividend) ? neg32(part[2*WIDTH-1:WIDTH])
                                              : part[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= DivFree;
    else     state <= state_next;
  end

  // Next-state decode and busy indication.
  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    case (state)
      DivFree: begin
        if (accept) begin
          busy_o     = 1'b1;
          state_next = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        busy_o     = 1'b1;
        state_next = annul_i ? DivFree : DivEnd;
      end
      DivOn: begin
        busy_o = 1'b1;
        if (annul_i)           state_next = DivFree;
        else if (cnt == 6'd32) state_next = DivEnd;
      end
      DivEnd: begin
        if (start_i == DivStop) state_next = DivFree;
      end
      default: state_next = DivFree;
    endcase
  end

  // Operand latch, iteration datapath and registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      part         <= '0;
      divisor      <= '0;
      signed_q     <= 1'b0;
      neg_dividend <= 1'b0;
      neg_divisor  <= 1'b0;
      result_o     <= '0;
      ready_o      <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (accept) begin
            signed_q     <= signed_div_i;
            neg_dividend <= signed_div_i & opdata1_i[WIDTH-1];
            neg_divisor  <= signed_div_i & opdata2_i[WIDTH-1];
            part         <= {{WIDTH{1'b0}}, abs_op1};
            divisor      <= abs_op2;
            cnt          <= '0;
          end
        end
        DivByZero: begin
          result_o <= '0;
          ready_o  <= annul_i ? DivResultNotReady : DivResultReady;
        end
        DivOn: begin
          if (annul_i) begin
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (cnt != 6'd32) begin
            if (trial[WIDTH]) part <= part_shift[2*WIDTH-1:0];
            else              part <= {trial[WIDTH-1:0], part_shift[WIDTH-1:1], 1'b1};
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule
